// File: rtl/bcd_display_ctrl.sv
// Two-digit BCD up/down counter with run/hold/clear/preload control.
// It drives the ones and tens digits of the seven-segment display path.
module bcd_display_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] CTRL0,
  output logic [3:0] CTRL1,
  output logic       running,
  output logic       wrap,
  output logic       load_err
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [7:0]         count_reg;
  logic [7:0]         count_next;
  logic [1:0]         is_term;
  logic [1:0]         carry_in;
  logic               step_wrap;
  logic               step_due;
  logic               load_ok;
  logic               run_tick;

  // A digit is "terminal" when stepping it wraps (9 going up, 0 going down).
  // A digit steps only when every lower digit is terminal, which gives the
  // carry/borrow chain without a combinational loop between stages.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = count_reg[4*gi +: 4];
      assign is_term[gi] = up ? (digit >= 4'd9) : (digit == 4'd0);

      if (gi == 0) begin : g_lsd
        assign carry_in[gi] = 1'b1;
      end else begin : g_msd
        assign carry_in[gi] = &is_term[gi-1:0];
      end

      assign count_next[4*gi +: 4] =
          !carry_in[gi] ? digit :
          is_term[gi]   ? (up ? 4'd0 : 4'd9) :
          up            ? digit + 4'd1 : digit - 4'd1;
    end
  endgenerate

  assign step_wrap = &is_term;
  assign step_due  = (state_reg == RUN) && (presc_reg == PRESC_LAST);
  assign load_ok   = (state_reg != RUN) &&
                     (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

  // The prescaler advances in RUN unless a higher-priority command takes the
  // cycle; a load outranks stop, so stop is ignored while load is asserted.
  assign run_tick = (state_reg == RUN) && !clear && (load || !stop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      count_reg <= 8'h00;
      running   <= 1'b0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;

      if (clear) begin
        state_reg <= IDLE;
        presc_reg <= '0;
        count_reg <= 8'h00;
        running   <= 1'b0;
      end else begin
        if (load) begin
          if (load_ok) begin
            count_reg <= load_val;
          end else begin
            load_err <= 1'b1;
          end
        end else if (stop) begin
          if (state_reg == RUN) begin
            state_reg <= HOLD;
            running   <= 1'b0;
          end
        end else if (start && (state_reg != RUN)) begin
          state_reg <= RUN;
          presc_reg <= '0;
          running   <= 1'b1;
        end

        // A load in RUN is always rejected, so it never collides with a step.
        if (run_tick) begin
          if (step_due) begin
            presc_reg <= '0;
            count_reg <= count_next;
            wrap      <= step_wrap;
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end
      end
    end
  end

  assign CTRL0 = count_reg[3:0];
  assign CTRL1 = count_reg[7:4];

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with TICK_DIV=4: load, run, hold,
// rejected loads, command collisions, async reset and full up/down sweeps.
module tb_bcd_display_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ctrl0;
  logic [3:0] ctrl1;
  logic       running;
  logic       wrap;
  logic       load_err;

  int errors = 0;
  int checks = 0;

  bcd_display_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .CTRL0    (ctrl0),
    .CTRL1    (ctrl1),
    .running  (running),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Assumes the caller sits one cycle after a step (or start) edge.
  task automatic expect_step(input logic [7:0] prev, input logic [7:0] nxt, input logic w);
    for (int i = 0; i < TICK_DIV - 1; i++) begin
      cyc();
      check("pre_step_count", {ctrl1, ctrl0}, prev);
      check("pre_step_wrap", wrap, 1'b0);
    end
    cyc();
    check("step_count", {ctrl1, ctrl0}, nxt);
    check("step_wrap", wrap, w);
    check("step_running", running, 1'b1);
    $display("step %h -> %h wrap=%0b", prev, {ctrl1, ctrl0}, wrap);
  endtask

  task automatic check_bcd();
    check("bcd_ones", ctrl0 <= 4'd9, 1'b1);
    check("bcd_tens", ctrl1 <= 4'd9, 1'b1);
  endtask

  initial begin
    int v;
    int wraps;

    // Reset values
    #12;
    check("rst_count", {ctrl1, ctrl0}, 8'h00);
    check("rst_running", running, 1'b0);
    check("rst_wrap", wrap, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    $display("reset checked");
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // 1: load in IDLE
    load = 1'b1; load_val = 8'h37;
    cyc();
    load = 1'b0;
    check("load37_count", {ctrl1, ctrl0}, 8'h37);
    check("load37_err", load_err, 1'b0);
    $display("load 37 -> %h", {ctrl1, ctrl0});

    // 2: count up through 99 -> 00
    load = 1'b1; load_val = 8'h95;
    cyc();
    load = 1'b0;
    up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_running", running, 1'b1);
    check("start_count", {ctrl1, ctrl0}, 8'h95);
    expect_step(8'h95, 8'h96, 1'b0);
    expect_step(8'h96, 8'h97, 1'b0);
    expect_step(8'h97, 8'h98, 1'b0);
    expect_step(8'h98, 8'h99, 1'b0);
    expect_step(8'h99, 8'h00, 1'b1);
    cyc();
    check("wrap_one_cycle", wrap, 1'b0);

    // 3: count down through 00 -> 99, hold, resume
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_running", running, 1'b0);
    load = 1'b1; load_val = 8'h01;
    cyc();
    load = 1'b0;
    check("load01_count", {ctrl1, ctrl0}, 8'h01);
    up = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    expect_step(8'h01, 8'h00, 1'b0);
    expect_step(8'h00, 8'h99, 1'b1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("hold_running", running, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("hold_frozen", {ctrl1, ctrl0}, 8'h99);
    end
    $display("hold 12 cycles at %h", {ctrl1, ctrl0});
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_step(8'h99, 8'h98, 1'b0);

    // 4: rejected loads
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    load = 1'b1; load_val = 8'h4A;
    cyc();
    load = 1'b0;
    check("load4A_err", load_err, 1'b1);
    check("load4A_count", {ctrl1, ctrl0}, 8'h98);
    cyc();
    check("load_err_pulse", load_err, 1'b0);
    $display("load 4A in HOLD rejected");
    start = 1'b1;
    cyc();
    start = 1'b0;
    load = 1'b1; load_val = 8'h21;
    cyc();
    load = 1'b0;
    check("load21_err", load_err, 1'b1);
    check("load21_count", {ctrl1, ctrl0}, 8'h98);
    check("load21_running", running, 1'b1);
    $display("load 21 in RUN rejected");

    // 5: collisions
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_count", {ctrl1, ctrl0}, 8'h00);
    clear = 1'b1; start = 1'b1;
    cyc();
    clear = 1'b0; start = 1'b0;
    check("clr_start_running", running, 1'b0);
    check("clr_start_count", {ctrl1, ctrl0}, 8'h00);
    cyc();
    check("clr_start_idle", running, 1'b0);
    $display("clear+start -> IDLE");

    load = 1'b1; load_val = 8'h50;
    cyc();
    load = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (TICK_DIV - 1) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_step_count", {ctrl1, ctrl0}, 8'h50);
    check("stop_step_running", running, 1'b0);
    check("stop_step_wrap", wrap, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stop_step_hold", {ctrl1, ctrl0}, 8'h50);
    end
    $display("stop on step cycle -> %h", {ctrl1, ctrl0});

    load = 1'b1; load_val = 8'h99;
    cyc();
    load = 1'b0;
    up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (TICK_DIV - 1) cyc();
    check("pre_clear_count", {ctrl1, ctrl0}, 8'h99);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_step_count", {ctrl1, ctrl0}, 8'h00);
    check("clear_step_wrap", wrap, 1'b0);
    check("clear_step_running", running, 1'b0);
    cyc();
    check("clear_step_wrap_late", wrap, 1'b0);
    $display("clear on step cycle -> %h", {ctrl1, ctrl0});

    // Async reset mid-RUN
    load = 1'b1; load_val = 8'h42;
    cyc();
    load = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_step(8'h42, 8'h43, 1'b0);
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", {ctrl1, ctrl0}, 8'h00);
    check("async_rst_running", running, 1'b0);
    check("async_rst_wrap", wrap, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    check("post_rst_count", {ctrl1, ctrl0}, 8'h00);
    check("post_rst_running", running, 1'b0);
    $display("async reset mid-RUN -> %h", {ctrl1, ctrl0});

    // 6: full sweep up, then down
    up = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    v = 0;
    wraps = 0;
    for (int s = 0; s < 100; s++) begin
      repeat (TICK_DIV - 1) begin
        cyc();
        check_bcd();
      end
      cyc();
      v = (v + 1) % 100;
      check("sweep_up_count", {ctrl1, ctrl0}, to_bcd(v));
      check("sweep_up_wrap", wrap, (v == 0));
      check_bcd();
      wraps += int'(wrap);
    end
    check("sweep_up_wraps", wraps, 1);
    $display("sweep up lap done wraps=%0d", wraps);

    up = 1'b0;
    wraps = 0;
    for (int s = 0; s < 100; s++) begin
      repeat (TICK_DIV - 1) begin
        cyc();
        check_bcd();
      end
      cyc();
      v = (v + 99) % 100;
      check("sweep_dn_count", {ctrl1, ctrl0}, to_bcd(v));
      check("sweep_dn_wrap", wrap, (v == 99));
      check_bcd();
      wraps += int'(wrap);
    end
    check("sweep_dn_wraps", wraps, 1);
    $display("sweep down lap done wraps=%0d", wraps);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
